// File: rtl/stream_combiner2.sv
// Two-stream sample combiner: pairs A/B samples in order and emits (a+b)/2.
// Define STREAM_COMBINER_ROUND_EN for round-half-up instead of truncation.
module stream_combiner2 #(
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   parameter int CW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [DW-1:0] a_data,
   input  logic          b_valid,
   output logic          b_ready,
   input  logic [DW-1:0] b_data,
   output logic          y_valid,
   input  logic          y_ready,
   output logic [DW-1:0] y_data,
   output logic          skew_err,
   output logic [CW-1:0] beat_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_a_q [DEPTH];
   logic [DW-1:0] mem_b_q [DEPTH];
   logic [AW-1:0] wptr_a_q, wptr_a_d, rptr_a_q, rptr_a_d;
   logic [AW-1:0] wptr_b_q, wptr_b_d, rptr_b_q, rptr_b_d;
   logic [AW:0]   occ_a_q, occ_a_d, occ_b_q, occ_b_d;
   logic          run_q;
   logic          yv_q, yv_d;
   logic [DW-1:0] yd_q, yd_d;
   logic          skew_q, skew_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          push_a, push_b, pop;
   logic [DW:0]   sum;

   // Ready is held low from reset until the first edge after release.
   assign a_ready = run_q && (occ_a_q != OCC_FULL);
   assign b_ready = run_q && (occ_b_q != OCC_FULL);

   assign push_a = a_valid && a_ready;
   assign push_b = b_valid && b_ready;
   assign pop    = (occ_a_q != '0) && (occ_b_q != '0) &&
                   (!yv_q || y_ready);

   always_comb begin
      sum = {mem_a_q[rptr_a_q][DW-1], mem_a_q[rptr_a_q]} +
            {mem_b_q[rptr_b_q][DW-1], mem_b_q[rptr_b_q]};
`ifdef STREAM_COMBINER_ROUND_EN
      sum = sum + (DW+1)'(1);
`endif
   end

   always_comb begin
      wptr_a_d = wptr_a_q;
      wptr_b_d = wptr_b_q;
      rptr_a_d = rptr_a_q;
      rptr_b_d = rptr_b_q;
      yv_d     = yv_q;
      yd_d     = yd_q;
      cnt_d    = cnt_q;
      skew_d   = skew_q;
      occ_a_d  = occ_a_q + {{AW{1'b0}}, push_a} - {{AW{1'b0}}, pop};
      occ_b_d  = occ_b_q + {{AW{1'b0}}, push_b} - {{AW{1'b0}}, pop};
      if (push_a) wptr_a_d = wptr_a_q + AW'(1);
      if (push_b) wptr_b_d = wptr_b_q + AW'(1);
      if (pop) begin
         rptr_a_d = rptr_a_q + AW'(1);
         rptr_b_d = rptr_b_q + AW'(1);
         yv_d     = 1'b1;
         yd_d     = sum[DW:1];
      end else if (yv_q && y_ready) begin
         yv_d = 1'b0;
      end
      if (yv_q && y_ready) cnt_d = cnt_q + CW'(1);
      if (((occ_a_q == OCC_FULL) && (occ_b_q == '0)) ||
          ((occ_b_q == OCC_FULL) && (occ_a_q == '0)))
         skew_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_a_q <= '0;
         wptr_b_q <= '0;
         rptr_a_q <= '0;
         rptr_b_q <= '0;
         occ_a_q  <= '0;
         occ_b_q  <= '0;
         run_q    <= 1'b0;
         yv_q     <= 1'b0;
         yd_q     <= '0;
         skew_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         wptr_a_q <= wptr_a_d;
         wptr_b_q <= wptr_b_d;
         rptr_a_q <= rptr_a_d;
         rptr_b_q <= rptr_b_d;
         occ_a_q  <= occ_a_d;
         occ_b_q  <= occ_b_d;
         run_q    <= 1'b1;
         yv_q     <= yv_d;
         yd_q     <= yd_d;
         skew_q   <= skew_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push_a) mem_a_q[wptr_a_q] <= a_data;
      if (push_b) mem_b_q[wptr_b_q] <= b_data;
   end

   assign y_valid  = yv_q;
   assign y_data   = yd_q;
   assign skew_err = skew_q;
   assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_stream_combiner2.sv
// Directed and randomized checks for stream_combiner2 (DW=16, DEPTH=4).
module tb_stream_combiner2;

   logic        clk;
   logic        rst;
   logic        a_valid, a_ready;
   logic [15:0] a_data;
   logic        b_valid, b_ready;
   logic [15:0] b_data;
   logic        y_valid, y_ready;
   logic [15:0] y_data;
   logic        skew_err;
   logic [15:0] beat_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   stream_combiner2 #(.DW(16), .DEPTH(4), .CW(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .a_data   (a_data),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .b_data   (b_data),
      .y_valid  (y_valid),
      .y_ready  (y_ready),
      .y_data   (y_data),
      .skew_err (skew_err),
      .beat_cnt (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [15:0] avg(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {a[15], a} + {b[15], b};
`ifdef STREAM_COMBINER_ROUND_EN
      s = s + 17'd1;
`endif
      return s[16:1];
   endfunction

   task automatic push_pair(input logic [15:0] a, input logic [15:0] b,
                            output logic [15:0] d, output logic v);
      @(negedge clk);
      a_valid = 1'b1; a_data = a;
      b_valid = 1'b1; b_data = b;
      y_ready = 1'b1;
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      v = y_valid; d = y_data;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b0;
      a_data = '0; b_data = '0;
      #1;
      n_checks++;
      if (y_valid !== 1'b0 || y_data !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_y: got v=%b d=%h want v=0 d=0000", y_valid, y_data);
      end
      n_checks++;
      if (skew_err !== 1'b0 || beat_cnt !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_flags: got skew=%b cnt=%0d want 0 0", skew_err, beat_cnt);
      end
      n_checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL release_ready: got a=%b b=%b want 1 1", a_ready, b_ready);
      end
   endtask

   task automatic test_single_pair;
      @(negedge clk);
      a_valid = 1'b1; a_data = 16'd100;
      b_valid = 1'b1; b_data = 16'd50;
      y_ready = 1'b1;
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      n_checks++;
      if (y_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_early: got y_valid=%b want 0", y_valid);
      end
      @(negedge clk);
      n_checks++;
      if (y_valid !== 1'b1 || y_data !== 16'd75) begin
         n_fail++;
         $display("FAIL single_data: got v=%b d=%0d want v=1 d=75", y_valid, y_data);
      end
      @(negedge clk);
      n_checks++;
      if (beat_cnt !== 16'd1 || y_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_beat: got cnt=%0d v=%b want 1 0", beat_cnt, y_valid);
      end
   endtask

   task automatic test_signed;
      logic [15:0] d;
      logic        v;
      logic [15:0] e;
`ifdef STREAM_COMBINER_ROUND_EN
      e = 16'hFFFF;
`else
      e = 16'hFFFE;
`endif
      push_pair(16'hFFFD, 16'h0000, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== e) begin
         n_fail++;
         $display("FAIL neg_odd: got v=%b d=%h want v=1 d=%h", v, d, e);
      end
      push_pair(16'h7FFF, 16'h7FFF, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== 16'h7FFF) begin
         n_fail++;
         $display("FAIL max_pos: got v=%b d=%h want v=1 d=7fff", v, d);
      end
      push_pair(16'h8000, 16'h8000, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== 16'h8000) begin
         n_fail++;
         $display("FAIL max_neg: got v=%b d=%h want v=1 d=8000", v, d);
      end
   endtask

   task automatic test_backpressure;
      int          na, nb, got;
      logic        stable;
      logic [15:0] out [8];
      logic [15:0] c0;
      logic [15:0] dc;
      na = 0; nb = 0; got = 0; stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         y_ready = 1'b0;
         if (y_valid && y_data !== 16'd1) stable = 1'b0;
         a_valid = 1'b1; a_data = 16'(10 * na);
         b_valid = 1'b1; b_data = 16'(10 * nb + 2);
         if (a_ready) na++;
         if (b_ready) nb++;
      end
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      n_checks++;
      if (na != 5 || nb != 5) begin
         n_fail++;
         $display("FAIL bp_accept: got a=%0d b=%0d want 5 5", na, nb);
      end
      n_checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_ready: got a=%b b=%b want 0 0", a_ready, b_ready);
      end
      n_checks++;
      if (y_valid !== 1'b1 || y_data !== 16'd1 || !stable) begin
         n_fail++;
         $display("FAIL bp_hold: got v=%b d=%0d stable=%b want 1 1 1", y_valid, y_data, stable);
      end
      c0 = beat_cnt;
      y_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (y_valid && y_ready && got < 8) begin
            out[got] = y_data;
            got++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (got != 5) begin
         n_fail++;
         $display("FAIL bp_count: got %0d beats want 5", got);
      end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (i < got && out[i] !== 16'(10 * i + 1)) begin
            n_fail++;
            $display("FAIL bp_order[%0d]: got %0d want %0d", i, out[i], 10 * i + 1);
         end
      end
      dc = beat_cnt - c0;
      n_checks++;
      if (dc !== 16'd5) begin
         n_fail++;
         $display("FAIL bp_beats: got delta %0d want 5", dc);
      end
   endtask

   task automatic test_skew;
      logic [15:0] av [4];
      logic [15:0] bv [4];
      logic [15:0] ev [4];
      logic [15:0] out [8];
      int          nb, got;
      logic        acc;
      av[0] = -16'sd7;    bv[0] = 16'sd3;
      av[1] = 16'sd5;     bv[1] = 16'sd4;
      av[2] = 16'sd100;   bv[2] = -16'sd50;
      av[3] = -16'sd1000; bv[3] = 16'sd999;
`ifdef STREAM_COMBINER_ROUND_EN
      ev[0] = -16'sd2; ev[1] = 16'sd5; ev[2] = 16'sd25; ev[3] = 16'sd0;
`else
      ev[0] = -16'sd2; ev[1] = 16'sd4; ev[2] = 16'sd25; ev[3] = -16'sd1;
`endif
      @(negedge clk);
      y_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_valid = 1'b1; a_data = av[i];
         @(negedge clk);
      end
      a_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b0 || y_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL skew_stall: got a_ready=%b y_valid=%b want 0 0", a_ready, y_valid);
      end
      n_checks++;
      if (skew_err !== 1'b1) begin
         n_fail++;
         $display("FAIL skew_set: got %b want 1", skew_err);
      end
      nb = 0; got = 0;
      for (int i = 0; i < 15; i++) begin
         b_valid = (nb < 4);
         if (nb < 4) b_data = bv[nb];
         acc = b_valid && b_ready;
         if (y_valid && got < 8) begin
            out[got] = y_data;
            got++;
         end
         @(negedge clk);
         if (acc) nb++;
      end
      b_valid = 1'b0;
      n_checks++;
      if (got != 4 || nb != 4) begin
         n_fail++;
         $display("FAIL skew_count: got outs=%0d pushes=%0d want 4 4", got, nb);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i < got && out[i] !== ev[i]) begin
            n_fail++;
            $display("FAIL skew_data[%0d]: got %h want %h", i, out[i], ev[i]);
         end
      end
      n_checks++;
      if (skew_err !== 1'b1) begin
         n_fail++;
         $display("FAIL skew_sticky: got %b want 1", skew_err);
      end
   endtask

   task automatic test_stream;
      localparam int N = 1000;
      logic [15:0] a_arr [N];
      logic [15:0] b_arr [N];
      int          na, nb, nout, cyc, bad;
      logic        acc_a, acc_b;
      logic [15:0] c0, dc, e;
      for (int i = 0; i < N; i++) begin
         a_arr[i] = 16'($urandom);
         b_arr[i] = 16'($urandom);
      end
      na = 0; nb = 0; nout = 0; cyc = 0; bad = 0;
      acc_a = 1'b0; acc_b = 1'b0;
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      c0 = beat_cnt;
      while (nout < N && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (acc_a) begin na++; a_valid = 1'b0; end
         if (acc_b) begin nb++; b_valid = 1'b0; end
         if (!a_valid && na < N && $urandom_range(0, 3) != 0) begin
            a_valid = 1'b1; a_data = a_arr[na];
         end
         if (!b_valid && nb < N && $urandom_range(0, 3) != 0) begin
            b_valid = 1'b1; b_data = b_arr[nb];
         end
         acc_a = a_valid && a_ready;
         acc_b = b_valid && b_ready;
         y_ready = ($urandom_range(0, 3) != 0);
         if (y_valid && y_ready) begin
            e = avg(a_arr[nout], b_arr[nout]);
            n_checks++;
            if (y_data !== e) begin
               n_fail++;
               if (bad < 10)
                  $display("FAIL stream[%0d]: got %h want %h", nout, y_data, e);
               bad++;
            end
            nout++;
         end
      end
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      n_checks++;
      if (nout != N) begin
         n_fail++;
         $display("FAIL stream_timeout: got %0d beats want %0d", nout, N);
      end
      dc = beat_cnt - c0;
      n_checks++;
      if (dc !== 16'd1000) begin
         n_fail++;
         $display("FAIL stream_beats: got delta %0d want 1000", dc);
      end
   endtask

   task automatic test_reset_mid;
      logic [15:0] d;
      logic        v;
      int          extra;
      @(negedge clk);
      y_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a_valid = 1'b1; a_data = 16'(1000 + i);
         b_valid = 1'b1; b_data = 16'(2000 + i);
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (y_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_pre: got y_valid=%b want 1", y_valid);
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (y_valid !== 1'b0 || y_data !== 16'h0 || beat_cnt !== 16'h0 || skew_err !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_clear: got v=%b d=%h cnt=%0d skew=%b want 0 0 0 0",
                  y_valid, y_data, beat_cnt, skew_err);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1 || y_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_release: got a=%b b=%b v=%b want 1 1 0", a_ready, b_ready, y_valid);
      end
      push_pair(16'sd20, -16'sd40, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== 16'hFFF6) begin
         n_fail++;
         $display("FAIL rmid_new: got v=%b d=%h want v=1 d=fff6", v, d);
      end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (y_valid) extra++;
      end
      n_checks++;
      if (extra != 0 || beat_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL rmid_stale: got extra=%0d cnt=%0d want 0 1", extra, beat_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_single_pair;
      test_signed;
      test_backpressure;
      test_skew;
      test_stream;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
